// File: rtl/bat_alert_pkg.sv
// Shared constants for the battery alert controller: FSM state codes,
// register addresses and a small pulse-length helper.
package bat_alert_pkg;

  // State codes are visible to software through CMD reads, so they are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_STATUS    = 2'd0;
  localparam logic [1:0] ADDR_CTRL      = 2'd1;
  localparam logic [1:0] ADDR_PULSE_LEN = 2'd2;
  localparam logic [1:0] ADDR_CMD       = 2'd3;

  // A programmed length of zero still produces a one-cycle pulse.
  function automatic logic [7:0] eff_pulse_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/bat_alert_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
// 'level' only changes after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles. 'fall' strobes on the cycle whose
// edge drives 'level' from 1 to 0, so consumers register it on that same edge.
module bat_alert_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             settle;

  assign mismatch = (sync_p1 != level);
  assign settle   = mismatch && (cnt == CNT_LAST);
  assign fall     = settle && !sync_p1;

  // Synchronizer stages; idle line level is high, so they reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Stability counter: any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (mismatch) begin
      if (settle) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/bat_alert_ctrl.sv
// Avalon-MM battery alert controller. Watches an open-drain active-low alert
// line, latches falls into a pending flag / interrupt, and can answer an
// alert by pulling the line low for a programmable acknowledge pulse, then
// waiting for the line to return high before accepting a new pulse.
module bat_alert_ctrl
  import bat_alert_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_RST       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        line_in,
  output logic        line_oe
);

  logic       level;
  logic       fall;
  state_t     state;
  logic       pending;
  logic       irq_en;
  logic       auto_ack;
  logic [7:0] pulse_len;
  logic [7:0] pulse_cnt;
  logic       auto_go;

  logic       wr_en;
  logic       wr_status;
  logic       wr_ctrl;
  logic       wr_len;
  logic       cmd_go;
  logic       pend_set;
  logic       pend_clr;
  logic       start_pulse;
  logic       unused_wdata;

  bat_alert_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (line_in),
    .level(level),
    .fall (fall)
  );

  assign wr_en     = chipselect && !write_n;
  assign wr_status = wr_en && (address == ADDR_STATUS);
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_len    = wr_en && (address == ADDR_PULSE_LEN);
  assign cmd_go    = wr_en && (address == ADDR_CMD) && writedata[0];

  // Falls are only recorded while idle; our own pulse must not re-arm pending.
  assign pend_set  = fall && (state == ST_IDLE);
  assign pend_clr  = wr_status && writedata[1];

  // A pulse starts from idle only; commands arriving while busy are dropped.
  assign start_pulse = (state == ST_IDLE) && (cmd_go || (auto_go && auto_ack));

  assign irq = pending && irq_en;

  assign unused_wdata = ^writedata[31:8];

  // Software-visible control registers and the pending flag (set wins over clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      irq_en    <= 1'b0;
      auto_ack  <= 1'b0;
      pulse_len <= 8'(PULSE_RST);
      auto_go   <= 1'b0;
    end else begin
      if (pend_set) begin
        pending <= 1'b1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
      if (wr_ctrl) begin
        irq_en   <= writedata[0];
        auto_ack <= writedata[1];
      end
      if (wr_len) begin
        pulse_len <= writedata[7:0];
      end
      // Auto-acknowledge fires on the cycle after pending is set.
      auto_go <= pend_set;
    end
  end

  // Acknowledge FSM; the pulse length is captured at entry to DRIVE so
  // PULSE_LEN writes during a pulse only affect the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      line_oe   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_pulse) begin
            state     <= ST_DRIVE;
            line_oe   <= 1'b1;
            pulse_cnt <= eff_pulse_len(pulse_len);
          end
        end
        ST_DRIVE: begin
          if (pulse_cnt <= 8'd1) begin
            state     <= ST_RECOVER;
            line_oe   <= 1'b0;
            pulse_cnt <= '0;
          end else begin
            pulse_cnt <= pulse_cnt - 8'd1;
          end
        end
        ST_RECOVER: begin
          if (level) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          line_oe <= 1'b0;
        end
      endcase
    end
  end

  // Read mux is registered every cycle regardless of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_STATUS:    readdata <= {29'd0, (state != ST_IDLE), pending, level};
        ADDR_CTRL:      readdata <= {30'd0, auto_ack, irq_en};
        ADDR_PULSE_LEN: readdata <= {24'd0, pulse_len};
        default:        readdata <= {30'd0, state};
      endcase
    end
  end

endmodule
